sram_dp_param: RTL

Parametrised, single-clock, dual read/write-port SRAM behavioural model for the Catapult memory-macro library. It supersedes the fixed-size per-macro models. Depth, word width, write-mask granularity and read latency are parameters. It adds async reset of the output path, per-byte write masks, out-of-range address handling, a read-valid pipeline and defined same-address collision behaviour. It sits under the HLS-generated accelerator datapath as the on-chip buffer macro, e.g. 128 x 1296 or 64 x 512.

---
 rtl/sram_pkg.sv | 46 ++++
 rtl/sram_rd_pipe.sv | 66 ++++++
 rtl/sram_dp_param.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the parametrised dual-port SRAM model:
// legal read-latency range, access decode and lane-masked write merge.
package sram_pkg;

  localparam int SRAM_LAT_MIN = 1;
  localparam int SRAM_LAT_MAX = 2;

  // Upper bounds for the width-generic merge helper; the top checks its
  // parameters against these at elaboration.
  localparam int SRAM_MAX_DW    = 2048;
  localparam int SRAM_MAX_LANES = 256;

  typedef logic [SRAM_MAX_DW-1:0]    sram_word_t;
  typedef logic [SRAM_MAX_LANES-1:0] sram_mask_t;

  typedef enum logic [1:0] {
    SRAM_IDLE,
    SRAM_RD,
    SRAM_WR
  } sram_op_e;

  // Active-low chip select and write enable decoded into one access type.
  function automatic sram_op_e decode_op(input logic csb, input logic web);
    if (csb) return SRAM_IDLE;
    return web ? SRAM_RD : SRAM_WR;
  endfunction

  // Replace the lanes of old_w selected by mask with the matching bits of
  // new_w. Callers zero-extend into the maximum width and keep the low bits.
  function automatic sram_word_t lane_merge(input sram_word_t  old_w,
                                            input sram_word_t  new_w,
                                            input sram_mask_t  mask,
                                            input int unsigned lane_w);
    sram_word_t  res;
    int unsigned lane;
    logic [7:0]  lane_idx;
    res = old_w;
    for (int unsigned b = 0; b < SRAM_MAX_DW; b++) begin
      lane     = (lane_w != 0) ? (b / lane_w) : SRAM_MAX_LANES;
      lane_idx = 8'(lane);
      if (lane < SRAM_MAX_LANES && mask[lane_idx]) res[b] = new_w[b];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-return pipeline for one SRAM port: carries {data, valid, oob}
// through READ_LATENCY register stages. Data registers hold their value
// between reads; everything clears asynchronously on rst.
module sram_rd_pipe
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH   = 128,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en_i,
  input  logic                  oob_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  oob_o
);

  logic [DATA_WIDTH-1:0] data1_q;
  logic                  valid1_q;
  logic                  oob1_q;

  // First stage: capture the addressed word at the sampling edge.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data1_q  <= '0;
      valid1_q <= 1'b0;
      oob1_q   <= 1'b0;
    end else begin
      valid1_q <= rd_en_i;
      oob1_q   <= rd_en_i & oob_i;
      if (rd_en_i) data1_q <= data_i;
    end
  end

  if (READ_LATENCY == SRAM_LAT_MAX) begin : g_lat2
    logic [DATA_WIDTH-1:0] data2_q;
    logic                  valid2_q;
    logic                  oob2_q;

    // Second stage: extra output register for the two-cycle macro flavour.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data2_q  <= '0;
        valid2_q <= 1'b0;
        oob2_q   <= 1'b0;
      end else begin
        valid2_q <= valid1_q;
        oob2_q   <= oob1_q;
        if (valid1_q) data2_q <= data1_q;
      end
    end

    assign data_o  = data2_q;
    assign valid_o = valid2_q;
    assign oob_o   = oob2_q;
  end else begin : g_lat1
    assign data_o  = data1_q;
    assign valid_o = valid1_q;
    assign oob_o   = oob1_q;
  end

endmodule

// File: rtl/sram_dp_param.sv
// Parametrised single-clock dual read/write-port SRAM behavioural model.
// Read-first on both ports; port 0 wins lanes written by both ports at the
// same address; out-of-range writes are dropped and reads return zero.
// Optional feature macro: SRAM_COLLISION_CHECK_EN adds the coll output.
module sram_dp_param
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH   = 128,
  parameter int RAM_DEPTH    = 1296,
  parameter int ADDR_WIDTH   = 11,
  parameter int WMASK_WIDTH  = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  output logic [DATA_WIDTH-1:0]  dout0,
  output logic                   dvalid0,
  output logic                   oob0,
  input  logic                   csb1,
  input  logic                   web1,
  input  logic [WMASK_WIDTH-1:0] wmask1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  input  logic [DATA_WIDTH-1:0]  din1,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   dvalid1,
  output logic                   oob1
`ifdef SRAM_COLLISION_CHECK_EN
  ,
  output logic                   coll
`endif
);

  localparam int unsigned LANE_W = DATA_WIDTH / WMASK_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(RAM_DEPTH);

  if (READ_LATENCY < SRAM_LAT_MIN || READ_LATENCY > SRAM_LAT_MAX ||
      WMASK_WIDTH < 1 || WMASK_WIDTH > SRAM_MAX_LANES ||
      DATA_WIDTH % WMASK_WIDTH != 0 || DATA_WIDTH >= SRAM_MAX_DW ||
      RAM_DEPTH < 2 || RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_params
    $error("sram_dp_param: illegal parameter combination");
  end

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  sram_op_e op0, op1;
  logic     in_rng0, in_rng1;
  logic     wr_en0, wr_en1;
  logic     same_addr;
  logic     wr_oob0_q, wr_oob1_q;
  logic     pipe_oob0, pipe_oob1;

  logic [DATA_WIDTH-1:0] rd_data0_d, rd_data1_d;
  logic [DATA_WIDTH-1:0] wr_data0_d, wr_data1_d;
  sram_word_t            merge0_w, merge1_w;
  logic                  unused_merge_hi;

  assign op0       = decode_op(csb0, web0);
  assign op1       = decode_op(csb1, web1);
  assign in_rng0   = {1'b0, addr0} < DEPTH_W;
  assign in_rng1   = {1'b0, addr1} < DEPTH_W;
  assign wr_en0    = (op0 == SRAM_WR) && in_rng0;
  assign wr_en1    = (op1 == SRAM_WR) && in_rng1;
  assign same_addr = (addr0 == addr1);

  // Pre-edge contents; out-of-range addresses read as zero.
  assign rd_data0_d = in_rng0 ? mem[addr0] : '0;
  assign rd_data1_d = in_rng1 ? mem[addr1] : '0;

  // Port 1 merges onto the stored word; port 0 merges on top of that when
  // both write the same word, so port 0 owns the lanes both ports enable.
  assign merge1_w   = lane_merge(SRAM_MAX_DW'(rd_data1_d), SRAM_MAX_DW'(din1),
                                 SRAM_MAX_LANES'(wmask1), LANE_W);
  assign wr_data1_d = merge1_w[DATA_WIDTH-1:0];
  assign merge0_w   = lane_merge(SRAM_MAX_DW'((wr_en1 && same_addr) ? wr_data1_d : rd_data0_d),
                                 SRAM_MAX_DW'(din0), SRAM_MAX_LANES'(wmask0), LANE_W);
  assign wr_data0_d = merge0_w[DATA_WIDTH-1:0];

  assign unused_merge_hi = ^{merge0_w[SRAM_MAX_DW-1:DATA_WIDTH],
                             merge1_w[SRAM_MAX_DW-1:DATA_WIDTH]};

  // Array update; port 0 is written last so its merged word wins a tie.
  // NOTE: the storage array has no reset; only the output path is cleared.
  always_ff @(posedge clk) begin
    if (wr_en1) mem[addr1] <= wr_data1_d;
    if (wr_en0) mem[addr0] <= wr_data0_d;
  end

  // Out-of-range write flags, one cycle after the sampling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_oob0_q <= 1'b0;
      wr_oob1_q <= 1'b0;
    end else begin
      wr_oob0_q <= (op0 == SRAM_WR) && !in_rng0;
      wr_oob1_q <= (op1 == SRAM_WR) && !in_rng1;
    end
  end

  sram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe0 (
    .clk    (clk),
    .rst    (rst),
    .rd_en_i(op0 == SRAM_RD),
    .oob_i  (!in_rng0),
    .data_i (rd_data0_d),
    .data_o (dout0),
    .valid_o(dvalid0),
    .oob_o  (pipe_oob0)
  );

  sram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe1 (
    .clk    (clk),
    .rst    (rst),
    .rd_en_i(op1 == SRAM_RD),
    .oob_i  (!in_rng1),
    .data_i (rd_data1_d),
    .data_o (dout1),
    .valid_o(dvalid1),
    .oob_o  (pipe_oob1)
  );

  assign oob0 = pipe_oob0 | wr_oob0_q;
  assign oob1 = pipe_oob1 | wr_oob1_q;

`ifdef SRAM_COLLISION_CHECK_EN
  logic coll_q;

  // Flag both ports hitting the same in-range word with at least one write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coll_q <= 1'b0;
    end else begin
      coll_q <= (op0 != SRAM_IDLE) && (op1 != SRAM_IDLE) && same_addr && in_rng0 &&
                ((op0 == SRAM_WR) || (op1 == SRAM_WR));
    end
  end

  assign coll = coll_q;
`endif

endmodule
